// File: rtl/cby_io_cfgchain_param_if.sv
// Signal bundle for the Y-channel IO connection block: config chain, tracks, grid pins and pad.
// The master side drives the block's inputs; the slave side is the block itself.
interface cby_io_cfgchain_param_if #(
   parameter int CHAN_W = 20,
   parameter int N_IPIN = 4
);
   logic              cfg_en;
   logic              ccff_head;
   logic              ccff_tail;
   logic              cfg_done;
   logic              cfg_err;
   logic [CHAN_W-1:0] chany_bottom_in;
   logic [CHAN_W-1:0] chany_top_in;
   logic [CHAN_W-1:0] chany_top_out;
   logic [CHAN_W-1:0] chany_bottom_out;
   logic [N_IPIN-1:0] ipin_out;
   logic              io_outpad;
   logic              io_inpad;
   logic              gfpga_pad_IN;
   logic              gfpga_pad_OUT;
   logic              gfpga_pad_DIR;

   modport master (
      output cfg_en, ccff_head, chany_bottom_in, chany_top_in, io_outpad, gfpga_pad_IN,
      input  ccff_tail, cfg_done, cfg_err, chany_top_out, chany_bottom_out, ipin_out,
             io_inpad, gfpga_pad_OUT, gfpga_pad_DIR
   );

   modport slave (
      input  cfg_en, ccff_head, chany_bottom_in, chany_top_in, io_outpad, gfpga_pad_IN,
      output ccff_tail, cfg_done, cfg_err, chany_top_out, chany_bottom_out, ipin_out,
             io_inpad, gfpga_pad_OUT, gfpga_pad_DIR
   );
endinterface

// File: rtl/cby_io_cfgchain_param.sv
// Y-channel connection block with one IO cell, configured over a scan chain.
// Selects come from a shadow register that only updates when a load has exactly CFG_BITS bits.
module cby_io_cfgchain_param #(
   parameter int CHAN_W   = 20,
   parameter int N_IPIN   = 4,
   parameter int MUX_SIZE = 10,
   parameter int STRIDE   = 3
) (
   input  logic                     prog_clk,
   input  logic                     pReset_n,
   cby_io_cfgchain_param_if.slave   bus
);
   localparam int SEL_W    = $clog2(MUX_SIZE);
   localparam int CFG_BITS = N_IPIN * SEL_W + 1;
   localparam int CNT_W    = $clog2(CFG_BITS + 2);
   localparam int MUX_PAD  = 1 << SEL_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic                 do_shift;
   logic                 start_load;
   logic                 do_commit;
   logic [CFG_BITS-1:0]  sr;
   logic [CFG_BITS-1:0]  sh;
   logic [CNT_W-1:0]     cnt;
   logic                 cfg_done_q;
   logic                 cfg_err_q;
   logic                 io_dir;

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // The first bit is shifted in the same cycle IDLE leaves for SHIFT.
   always_comb begin
      state_d    = state_q;
      do_shift   = 1'b0;
      start_load = 1'b0;
      do_commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cfg_en) begin
               do_shift   = 1'b1;
               start_load = 1'b1;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.cfg_en) do_shift = 1'b1;
            else            state_d  = COMMIT;
         end
         COMMIT: begin
            do_commit = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         sr         <= '0;
         sh         <= '0;
         cnt        <= '0;
         cfg_done_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         if (do_shift) sr <= {sr[CFG_BITS-2:0], bus.ccff_head};
         if (start_load) begin
            cnt        <= CNT_W'(1);
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
         end else if (do_shift && cnt != CNT_W'(CFG_BITS + 1)) begin
            cnt <= cnt + 1'b1;
         end
         // Short or overlong loads leave the live configuration untouched.
         if (do_commit) begin
            if (cnt == CNT_W'(CFG_BITS)) begin
               sh         <= sr;
               cfg_done_q <= 1'b1;
            end else begin
               cfg_err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.ccff_tail = sr[CFG_BITS-1];
   assign bus.cfg_done  = cfg_done_q;
   assign bus.cfg_err   = cfg_err_q;

   assign bus.chany_top_out    = bus.chany_bottom_in;
   assign bus.chany_bottom_out = bus.chany_top_in;

   // Mux inputs are padded to a power of two with zeros so out-of-range selects drive 0.
   for (genvar i = 0; i < N_IPIN; i++) begin : g_ipin
      logic [MUX_PAD-1:0] mux_in;
      logic [SEL_W-1:0]   sel;
      assign sel = sh[SEL_W*i +: SEL_W];
      for (genvar k = 0; k < MUX_PAD; k++) begin : g_in
         if (k >= MUX_SIZE) begin : g_pad
            assign mux_in[k] = 1'b0;
         end else if (k % 2 == 0) begin : g_bot
            assign mux_in[k] = bus.chany_bottom_in[(2*i + (k/2)*STRIDE) % CHAN_W];
         end else begin : g_top
            assign mux_in[k] = bus.chany_top_in[(2*i + (k/2)*STRIDE) % CHAN_W];
         end
      end
      assign bus.ipin_out[i] = mux_in[sel];
   end

   assign io_dir            = sh[CFG_BITS-1];
   assign bus.gfpga_pad_DIR = io_dir;
   assign bus.gfpga_pad_OUT = io_dir ? 1'b0 : bus.io_outpad;
   assign bus.io_inpad      = io_dir ? bus.gfpga_pad_IN : 1'b0;

endmodule

// File: tb/tb_cby_io_cfgchain_param.sv
// Bench for cby_io_cfgchain_param: table of configuration loads plus hand-written chain sequences,
// checked against a field-level model of the committed configuration.
module tb_cby_io_cfgchain_param;
   localparam int CHAN_W   = 20;
   localparam int N_IPIN   = 4;
   localparam int MUX_SIZE = 10;
   localparam int STRIDE   = 3;
   localparam int SEL_W    = $clog2(MUX_SIZE);
   localparam int CFG_BITS = N_IPIN * SEL_W + 1;

   typedef struct {
      logic [31:0] word;
      int          nbits;
      bit          exp_done;
      bit          exp_err;
   } load_vec_t;

   logic prog_clk = 1'b0;
   logic pReset_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   int   model_sel [N_IPIN];
   bit   model_dir;

   cby_io_cfgchain_param_if #(.CHAN_W(CHAN_W), .N_IPIN(N_IPIN)) bus ();

   cby_io_cfgchain_param #(
      .CHAN_W(CHAN_W), .N_IPIN(N_IPIN), .MUX_SIZE(MUX_SIZE), .STRIDE(STRIDE)
   ) dut (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .bus      (bus.slave)
   );

   always #5 prog_clk = ~prog_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_IPIN; i++) model_sel[i] = 0;
      model_dir = 1'b0;
   endtask

   // A complete load places the first bit in io_dir and sel_i at bits SEL_W*i.
   task automatic model_commit(input logic [31:0] w);
      for (int i = 0; i < N_IPIN; i++) model_sel[i] = int'((w >> (SEL_W * i)) & ((32'd1 << SEL_W) - 1));
      model_dir = w[CFG_BITS-1];
   endtask

   function automatic logic [N_IPIN-1:0] ref_ipin(input logic [CHAN_W-1:0] bot,
                                                  input logic [CHAN_W-1:0] top);
      logic [N_IPIN-1:0] r;
      int s, t;
      r = '0;
      for (int i = 0; i < N_IPIN; i++) begin
         s = model_sel[i];
         if (s < MUX_SIZE) begin
            t = (2 * i + (s / 2) * STRIDE) % CHAN_W;
            r[i] = (s % 2 == 1) ? top[t] : bot[t];
         end
      end
      return r;
   endfunction

   task automatic check_outputs(input string tag);
      logic [CHAN_W-1:0] bot, top;
      logic opad, pin;
      bot  = CHAN_W'($urandom);
      top  = CHAN_W'($urandom);
      opad = 1'($urandom);
      pin  = 1'($urandom);
      bus.chany_bottom_in = bot;
      bus.chany_top_in    = top;
      bus.io_outpad       = opad;
      bus.gfpga_pad_IN    = pin;
      #1;
      chk({tag, " top_out"},    32'(bus.chany_top_out),    32'(bot));
      chk({tag, " bottom_out"}, 32'(bus.chany_bottom_out), 32'(top));
      chk({tag, " ipin"},       32'(bus.ipin_out),         32'(ref_ipin(bot, top)));
      chk({tag, " pad_dir"},    32'(bus.gfpga_pad_DIR),    32'(model_dir));
      chk({tag, " pad_out"},    32'(bus.gfpga_pad_OUT),    32'(model_dir ? 1'b0 : opad));
      chk({tag, " inpad"},      32'(bus.io_inpad),         32'(model_dir ? pin : 1'b0));
   endtask

   task automatic shift_word(input logic [31:0] w, input int n);
      for (int b = n - 1; b >= 0; b--) begin
         @(negedge prog_clk);
         bus.cfg_en    = 1'b1;
         bus.ccff_head = w[b];
      end
      @(negedge prog_clk);
      bus.cfg_en    = 1'b0;
      bus.ccff_head = 1'b0;
   endtask

   task automatic run_load(input logic [31:0] w, input int n, input bit exp_done,
                           input bit exp_err, input string tag);
      shift_word(w, n);
      repeat (2) @(negedge prog_clk);
      if (n == CFG_BITS) model_commit(w);
      chk({tag, " done"}, 32'(bus.cfg_done), 32'(exp_done));
      chk({tag, " err"},  32'(bus.cfg_err),  32'(exp_err));
      repeat (3) check_outputs(tag);
   endtask

   load_vec_t vecs [7];

   initial begin
      logic [31:0] w;
      int          n;
      bit          hist [$];
      bit          b;

      vecs[0] = '{32'h0001_0005, 17, 1'b1, 1'b0};
      vecs[1] = '{32'h0000_ABCD, 16, 1'b0, 1'b1};
      vecs[2] = '{32'h0000_9C30, 17, 1'b1, 1'b0};
      vecs[3] = '{32'h0002_1234, 18, 1'b0, 1'b1};
      vecs[4] = '{32'h0001_FFFF, 17, 1'b1, 1'b0};
      vecs[5] = '{32'h0000_0001,  1, 1'b0, 1'b1};
      vecs[6] = '{32'h0000_8721, 17, 1'b1, 1'b0};

      bus.cfg_en = 1'b0;
      bus.ccff_head = 1'b0;
      bus.chany_bottom_in = '0;
      bus.chany_top_in = '0;
      bus.io_outpad = 1'b0;
      bus.gfpga_pad_IN = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(negedge prog_clk);
      chk("rst tail", 32'(bus.ccff_tail), 32'd0);
      chk("rst done", 32'(bus.cfg_done),  32'd0);
      chk("rst err",  32'(bus.cfg_err),   32'd0);
      check_outputs("rst");
      bus.chany_bottom_in = CHAN_W'(32'h0000_0004);
      #1;
      chk("rst ipin1 b2", 32'(bus.ipin_out[1]), 32'd1);
      @(negedge prog_clk);
      pReset_n = 1'b1;

      // Table of loads
      for (int v = 0; v < 7; v++) begin
         run_load(vecs[v].word, vecs[v].nbits, vecs[v].exp_done, vecs[v].exp_err,
                  $sformatf("vec%0d", v));
         if (v == 0) begin
            bus.chany_top_in = CHAN_W'(32'h0000_0040);
            bus.chany_bottom_in = '0;
            #1;
            chk("sel5 ipin0 top6", 32'(bus.ipin_out[0]), 32'd1);
         end
         if (v == 2) begin
            bus.chany_top_in = '1;
            bus.chany_bottom_in = '1;
            #1;
            chk("sel12 ipin2 zero", 32'(bus.ipin_out[2]), 32'd0);
         end
      end

      // Random loads
      for (int r = 0; r < 10; r++) begin
         w = $urandom;
         n = ($urandom_range(0, 1) == 1) ? CFG_BITS : $urandom_range(CFG_BITS - 2, CFG_BITS + 2);
         run_load(w, n, n == CFG_BITS, n != CFG_BITS, $sformatf("rnd%0d", r));
      end

      // Long stream: outputs hold the old configuration and the tail replays the head
      for (int j = 0; j < 40; j++) begin
         @(negedge prog_clk);
         if (j >= 1) begin
            chk($sformatf("stream done c%0d", j), 32'(bus.cfg_done), 32'd0);
            check_outputs($sformatf("stream c%0d", j));
         end
         if (j >= CFG_BITS) chk($sformatf("tail c%0d", j), 32'(bus.ccff_tail), 32'(hist[j - CFG_BITS]));
         b = 1'($urandom);
         hist.push_back(b);
         bus.cfg_en = 1'b1;
         bus.ccff_head = b;
      end
      @(negedge prog_clk);
      bus.cfg_en = 1'b0;
      repeat (2) @(negedge prog_clk);
      chk("stream err", 32'(bus.cfg_err), 32'd1);
      check_outputs("stream end");

      // Reset in the middle of a load
      run_load(32'h0001_5A5A, CFG_BITS, 1'b1, 1'b0, "pre-abort");
      w = 32'h0001_2468;
      for (int k = CFG_BITS - 1; k >= CFG_BITS - 9; k--) begin
         @(negedge prog_clk);
         bus.cfg_en = 1'b1;
         bus.ccff_head = w[k];
      end
      @(negedge prog_clk);
      pReset_n = 1'b0;
      bus.cfg_en = 1'b0;
      model_reset();
      #1;
      chk("abort done", 32'(bus.cfg_done),  32'd0);
      chk("abort err",  32'(bus.cfg_err),   32'd0);
      chk("abort tail", 32'(bus.ccff_tail), 32'd0);
      check_outputs("abort");
      @(negedge prog_clk);
      pReset_n = 1'b1;
      run_load(32'h0001_3579, CFG_BITS, 1'b1, 1'b0, "post-abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
